// File: rtl/crg_triple_checker_pkg.sv
// Shared types and helpers for the CRG triple checker.
// Lane geometry is derived from the 3-bit width code.
package crg_triple_checker_pkg;

  typedef logic [255:0] prng_t;
  typedef logic [31:0]  cr_cnt_t;

  typedef enum logic [2:0] {
    W32  = 3'b000,
    W64  = 3'b001,
    W128 = 3'b011,
    W256 = 3'b111
  } width_t;

  typedef enum logic [2:0] {
    M_ARITH = 3'b100,
    M_EXT   = 3'b001,
    M_BOOL  = 3'b010
  } mode_t;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_RECON = 2'd1;
  localparam state_t S_MUL   = 2'd2;
  localparam state_t S_CMP   = 2'd3;

  function automatic logic [8:0] lane_width(input width_t w);
    case (w)
      W32:     return 9'd32;
      W64:     return 9'd64;
      W128:    return 9'd128;
      default: return 9'd256;
    endcase
  endfunction

  function automatic prng_t lane_lsb_mask(input width_t w);
    case (w)
      W32:     return {8{32'd1}};
      W64:     return {4{64'd1}};
      W128:    return {2{128'd1}};
      default: return 256'd1;
    endcase
  endfunction

endpackage

// File: rtl/crg_triple_checker_seg_adder256.sv
// 256-bit adder built from 32-bit slices; the carry is
// killed at every lane base so lanes wrap independently.
import crg_triple_checker_pkg::*;

module crg_triple_checker_seg_adder256 (
  input  prng_t  a,
  input  prng_t  b,
  input  width_t w,
  output prng_t  sum
);

  always_comb begin
    prng_t       m;
    logic        cy;
    logic [32:0] s;
    m   = lane_lsb_mask(w);
    cy  = 1'b0;
    s   = '0;
    sum = '0;
    for (int j = 0; j < 8; j++) begin
      s = {1'b0, a[j*32 +: 32]}
        + {1'b0, b[j*32 +: 32]}
        + {32'd0, cy & ~m[j*32]};
      sum[j*32 +: 32] = s[31:0];
      cy = s[32];
    end
  end

endmodule

// File: rtl/crg_triple_checker.sv
// Reconstructs a/b/c from two share sets, checks c = a*b per
// lane (shift-add) or c = a&b, and keeps pass/fail statistics.
import crg_triple_checker_pkg::*;

module crg_triple_checker #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [2:0]       width_i,
  input  logic [2:0]       mode_i,
  input  logic             vld_i,
  output logic             rdy_o,
  input  prng_t            a0_i,
  input  prng_t            b0_i,
  input  prng_t            c0_i,
  input  prng_t            a1_i,
  input  prng_t            b1_i,
  input  prng_t            c1_i,
  input  logic [7:0]       e0_i,
  input  logic [7:0]       e1_i,
  output logic             res_vld_o,
  output logic             res_ok_o,
  output logic             res_eerr_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic [CNT_W-1:0] idx_o,
  output logic [CNT_W-1:0] first_fail_o,
  output logic             busy_o
);

  state_t           state;
  width_t           wid_q;
  logic [2:0]       mode_q;
  logic             bad_q, eb_q, cl_q, seen_q;
  prng_t            a_q, b_q, c_q, acc_q;
  logic [7:0]       k_q;
  logic [CNT_W-1:0] pass_q, fail_q, idx_q, tidx_q, ff_q;
  logic             vld_q, ok_q, ee_q;

  width_t win;
  logic   accept, is_bool, w_ok, m_ok;
  logic   ok_c, ee_c;
  prng_t  a_sum, b_sum, c_sum, a_rec, acc_sum, addend;
  logic [7:0] lm1;

  assign win     = width_t'(width_i);
  assign accept  = vld_i & rdy_o;
  assign is_bool = (mode_i == M_BOOL);
  assign w_ok    = width_i inside {W32, W64, W128, W256};
  assign m_ok    = mode_i inside {M_ARITH, M_EXT, M_BOOL};
  assign lm1     = 8'(lane_width(wid_q) - 9'd1);

  crg_triple_checker_seg_adder256 u_ra (
    .a(a0_i), .b(a1_i), .w(win), .sum(a_sum));
  crg_triple_checker_seg_adder256 u_rb (
    .a(b0_i), .b(b1_i), .w(win), .sum(b_sum));
  crg_triple_checker_seg_adder256 u_rc (
    .a(c0_i), .b(c1_i), .w(win), .sum(c_sum));
  crg_triple_checker_seg_adder256 u_acc (
    .a(acc_q), .b(addend), .w(wid_q), .sum(acc_sum));

  assign a_rec = is_bool ? (a0_i ^ a1_i) : a_sum;

  // each 32-bit slice lives in one lane; pick that lane's b bit k
  always_comb begin
    logic [7:0] bi;
    addend = '0;
    bi     = '0;
    for (int j = 0; j < 8; j++) begin
      bi = (8'(j * 32) & ~lm1) + k_q;
      if (b_q[bi]) addend[j*32 +: 32] = a_q[j*32 +: 32];
    end
  end

  assign ee_c = ~bad_q & (mode_q == M_EXT) & eb_q;
  assign ok_c = ~bad_q & ~ee_c &
    ((mode_q == M_BOOL) ? ((a_q & b_q) == c_q)
                        : (acc_q == c_q));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      wid_q  <= W32;
      mode_q <= '0;
      bad_q  <= 1'b0;
      eb_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      acc_q  <= '0;
      k_q    <= '0;
      vld_q  <= 1'b0;
      ok_q   <= 1'b0;
      ee_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      ok_q  <= 1'b0;
      ee_q  <= 1'b0;
      unique case (state)
        S_IDLE: if (accept) begin
          state  <= S_RECON;
          a_q    <= a_rec;
          b_q    <= is_bool ? (b0_i ^ b1_i) : b_sum;
          c_q    <= is_bool ? (c0_i ^ c1_i) : c_sum;
          wid_q  <= win;
          mode_q <= mode_i;
          bad_q  <= ~(w_ok & m_ok);
          eb_q   <= (e0_i ^ e1_i) != {a_rec[224], a_rec[192],
                     a_rec[160], a_rec[128], a_rec[96],
                     a_rec[64], a_rec[32], a_rec[0]};
        end
        S_RECON: begin
          acc_q <= '0;
          k_q   <= '0;
          state <= (bad_q | (mode_q == M_BOOL)) ? S_CMP : S_MUL;
        end
        S_MUL: begin
          acc_q <= acc_sum;
          a_q   <= (a_q << 1) & ~lane_lsb_mask(wid_q);
          k_q   <= k_q + 8'd1;
          if (k_q == lm1) state <= S_CMP;
        end
        S_CMP: begin
          vld_q <= 1'b1;
          ok_q  <= ok_c;
          ee_q  <= ee_c;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // a clear while a triple is in flight keeps it out of the stats
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pass_q <= '0;
      fail_q <= '0;
      idx_q  <= '0;
      tidx_q <= '0;
      ff_q   <= '1;
      seen_q <= 1'b0;
      cl_q   <= 1'b0;
    end else begin
      if (accept) begin
        tidx_q <= clr_i ? '0 : idx_q;
        idx_q  <= clr_i ? CNT_W'(1) : idx_q + CNT_W'(1);
      end else if (clr_i) begin
        idx_q <= '0;
      end
      if (accept) cl_q <= 1'b0;
      else if (clr_i && state != S_IDLE) cl_q <= 1'b1;
      if (clr_i) begin
        pass_q <= '0;
        fail_q <= '0;
        ff_q   <= '1;
        seen_q <= 1'b0;
      end else if (state == S_CMP && !cl_q) begin
        if (ok_c) begin
          if (~&pass_q) pass_q <= pass_q + CNT_W'(1);
        end else begin
          if (~&fail_q) fail_q <= fail_q + CNT_W'(1);
          if (!seen_q) begin
            ff_q   <= tidx_q;
            seen_q <= 1'b1;
          end
        end
      end
    end
  end

  assign rdy_o        = (state == S_IDLE);
  assign busy_o       = ~rdy_o;
  assign res_vld_o    = vld_q;
  assign res_ok_o     = ok_q;
  assign res_eerr_o   = ee_q;
  assign pass_cnt_o   = pass_q;
  assign fail_cnt_o   = fail_q;
  assign idx_o        = idx_q;
  assign first_fail_o = ff_q;

endmodule

// File: tb/tb_crg_triple_checker.sv
// Randomized self-checking bench for crg_triple_checker with a
// lane-arithmetic reference model and a statistics scoreboard.
module tb_crg_triple_checker;

  logic clk = 1'b0;
  logic rst_i, clr_i, vld_i;
  logic [2:0] width_i, mode_i;
  logic [255:0] a0_i, b0_i, c0_i, a1_i, b1_i, c1_i;
  logic [7:0] e0_i, e1_i;
  logic rdy_o, res_vld_o, res_ok_o, res_eerr_o, busy_o;
  logic [31:0] pass_cnt_o, fail_cnt_o, idx_o, first_fail_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_pass, exp_fail, exp_idx, exp_ff;
  bit ff_seen;

  always #5 clk = ~clk;

  crg_triple_checker #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i),
    .width_i(width_i), .mode_i(mode_i), .vld_i(vld_i),
    .rdy_o(rdy_o),
    .a0_i(a0_i), .b0_i(b0_i), .c0_i(c0_i),
    .a1_i(a1_i), .b1_i(b1_i), .c1_i(c1_i),
    .e0_i(e0_i), .e1_i(e1_i),
    .res_vld_o(res_vld_o), .res_ok_o(res_ok_o),
    .res_eerr_o(res_eerr_o),
    .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o),
    .idx_o(idx_o), .first_fail_o(first_fail_o),
    .busy_o(busy_o)
  );

  function automatic logic [255:0] r256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int lw_of(input logic [2:0] w);
    case (w)
      3'b000: return 32;
      3'b001: return 64;
      3'b011: return 128;
      3'b111: return 256;
      default: return 0;
    endcase
  endfunction

  function automatic logic [255:0] lmask(input int lw);
    logic [255:0] one;
    one = 256'd1;
    if (lw >= 256) return '1;
    return (one << lw) - one;
  endfunction

  function automatic logic [255:0] recon(input int lw, input logic [255:0] x0, x1);
    logic [255:0] r, mk;
    r = '0;
    mk = lmask(lw);
    for (int l = 0; l < 256 / lw; l++)
      r |= (((x0 >> (l*lw)) + (x1 >> (l*lw))) & mk) << (l*lw);
    return r;
  endfunction

  function automatic logic [7:0] abits(input logic [255:0] a);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = a[32*i];
    return r;
  endfunction

  function automatic void model(input logic [2:0] w, m,
      input logic [255:0] a0, a1, b0, b1, c0, c1,
      input logic [7:0] e0, e1,
      output bit ok, output bit ee, output int lat);
    int lw;
    logic [255:0] a, b, c, mk;
    lw = lw_of(w);
    ok = 0; ee = 0; lat = 2;
    if (lw == 0 || !(m inside {3'b100, 3'b001, 3'b010})) return;
    if (m == 3'b010) begin
      ok = (((a0 ^ a1) & (b0 ^ b1)) == (c0 ^ c1));
      return;
    end
    lat = lw + 2;
    mk = lmask(lw);
    a = recon(lw, a0, a1);
    b = recon(lw, b0, b1);
    c = recon(lw, c0, c1);
    ok = 1;
    for (int l = 0; l < 256 / lw; l++)
      if (((((a >> (l*lw)) & mk) * ((b >> (l*lw)) & mk)) & mk) != ((c >> (l*lw)) & mk))
        ok = 0;
    if (m == 3'b001 && (e0 ^ e1) != abits(a)) begin
      ee = 1;
      ok = 0;
    end
  endfunction

  function automatic void mk_valid(input logic [2:0] w, m,
      input logic [255:0] a0, a1, b0, b1, c0, input logic [7:0] e0,
      output logic [255:0] c1, output logic [7:0] e1);
    int lw;
    logic [255:0] a, b, mk, p;
    lw = lw_of(w);
    if (lw == 0) lw = 32;
    e1 = e0;
    if (m == 3'b010) begin
      c1 = ((a0 ^ a1) & (b0 ^ b1)) ^ c0;
      return;
    end
    mk = lmask(lw);
    a = recon(lw, a0, a1);
    b = recon(lw, b0, b1);
    c1 = '0;
    for (int l = 0; l < 256 / lw; l++) begin
      p = (((a >> (l*lw)) & mk) * ((b >> (l*lw)) & mk)) & mk;
      c1 |= ((p - ((c0 >> (l*lw)) & mk)) & mk) << (l*lw);
    end
    e1 = e0 ^ abits(a);
  endfunction

  task automatic sb_clear();
    exp_pass = 0; exp_fail = 0; exp_ff = '1; ff_seen = 0; exp_idx = 0;
  endtask

  task automatic sb_step(input bit ok, input int clr_at, input int lat);
    logic [31:0] ti;
    if (clr_at == 0) sb_clear();
    ti = exp_idx;
    exp_idx = exp_idx + 1;
    if (clr_at >= 1 && clr_at <= lat) sb_clear();
    else if (ok) exp_pass = exp_pass + 1;
    else begin
      exp_fail = exp_fail + 1;
      if (!ff_seen) begin exp_ff = ti; ff_seen = 1; end
    end
  endtask

  // called at #1 after an edge with the DUT idle
  task automatic run(input logic [2:0] w, m,
      input logic [255:0] a0, a1, b0, b1, c0, c1,
      input logic [7:0] e0, e1, input int clr_at,
      output bit got, output bit ok, output bit ee,
      output int lat, output bit rlow);
    width_i = w; mode_i = m;
    a0_i = a0; a1_i = a1; b0_i = b0; b1_i = b1;
    c0_i = c0; c1_i = c1; e0_i = e0; e1_i = e1;
    vld_i = 1'b1;
    clr_i = (clr_at == 0);
    @(posedge clk); #1;
    vld_i = 1'b0;
    clr_i = 1'b0;
    got = 0; ok = 0; ee = 0; lat = 0; rlow = 1;
    for (int i = 1; i <= 400 && !got; i++) begin
      clr_i = (i == clr_at);
      @(posedge clk); #1;
      clr_i = 1'b0;
      if (res_vld_o === 1'b1) begin
        got = 1; lat = i; ok = res_ok_o; ee = res_eerr_o;
      end else if (rdy_o !== 1'b0) rlow = 0;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; clr_i = 0; vld_i = 0;
    width_i = 0; mode_i = 3'b100;
    a0_i = 0; a1_i = 0; b0_i = 0; b1_i = 0; c0_i = 0; c1_i = 0;
    e0_i = 0; e1_i = 0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    sb_clear();
    checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %0b want 1", rdy_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
    checks++; if ({res_vld_o, res_ok_o, res_eerr_o} !== 3'b000) begin errors++; $display("FAIL reset_res: got %b want 000", {res_vld_o, res_ok_o, res_eerr_o}); end
    checks++; if ({pass_cnt_o, fail_cnt_o, idx_o} !== 96'd0) begin errors++; $display("FAIL reset_cnt: got %h want 0", {pass_cnt_o, fail_cnt_o, idx_o}); end
    checks++; if (first_fail_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_ff: got %h want ffffffff", first_fail_o); end
  endtask

  task automatic test_bool();
    bit got, ok, ee, rl; int lat;
    run(3'b000, 3'b010, 256'h0F, 256'hF0, 256'h3C, 256'h0, 256'h30, 256'h0C,
        8'h0, 8'h0, -1, got, ok, ee, lat, rl);
    sb_step(1, -1, 2);
    checks++; if (!got || ok !== 1'b1) begin errors++; $display("FAIL bool_ok: got %0b/%0b want 1/1", got, ok); end
    checks++; if (lat != 2) begin errors++; $display("FAIL bool_lat: got %0d want 2", lat); end
    checks++; if (pass_cnt_o !== 32'd1) begin errors++; $display("FAIL bool_pass: got %0d want 1", pass_cnt_o); end
  endtask

  task automatic test_a32();
    bit got, ok, ee, rl; int lat;
    run(3'b000, 3'b100, {8{32'd1}}, {8{32'd2}}, {8{32'd5}}, '0,
        {8{32'hFFFF_FFFF}}, {8{32'd16}}, 8'h0, 8'h0, -1, got, ok, ee, lat, rl);
    sb_step(1, -1, 34);
    checks++; if (!got || ok !== 1'b1) begin errors++; $display("FAIL a32_ok: got %0b/%0b want 1/1", got, ok); end
    checks++; if (lat != 34) begin errors++; $display("FAIL a32_lat: got %0d want 34", lat); end
    checks++; if (rl !== 1'b1) begin errors++; $display("FAIL a32_rdy_low: got %0b want 1", rl); end
  endtask

  task automatic test_a256_fail();
    bit got, ok, ee, rl; int lat;
    logic [255:0] a0, a1, b0, b1, c0, c1; logic [7:0] e1;
    clr_i = 1'b1; @(posedge clk); #1 clr_i = 1'b0;
    sb_clear();
    for (int n = 0; n < 4; n++) begin
      a0 = r256(); a1 = r256(); b0 = r256(); b1 = r256(); c0 = r256();
      mk_valid(3'b000, 3'b010, a0, a1, b0, b1, c0, 8'h0, c1, e1);
      run(3'b000, 3'b010, a0, a1, b0, b1, c0, c1, 8'h0, e1, -1, got, ok, ee, lat, rl);
      sb_step(1, -1, 2);
    end
    checks++; if (pass_cnt_o !== 32'd4) begin errors++; $display("FAIL a256_pre_pass: got %0d want 4", pass_cnt_o); end
    run(3'b111, 3'b100, 256'd2, '0, 256'd3, '0, 256'd7, '0, 8'h0, 8'h0,
        -1, got, ok, ee, lat, rl);
    sb_step(0, -1, 258);
    checks++; if (!got || ok !== 1'b0 || lat != 258) begin errors++; $display("FAIL a256_res: got %0b/%0b lat %0d want 1/0 lat 258", got, ok, lat); end
    checks++; if (fail_cnt_o !== 32'd1 || first_fail_o !== 32'd4) begin errors++; $display("FAIL a256_ff: got fail %0d ff %0d want 1 4", fail_cnt_o, first_fail_o); end
    run(3'b000, 3'b010, 256'h1, '0, 256'h1, '0, '0, '0, 8'h0, 8'h0,
        -1, got, ok, ee, lat, rl);
    sb_step(0, -1, 2);
    checks++; if (fail_cnt_o !== 32'd2 || first_fail_o !== 32'd4) begin errors++; $display("FAIL a256_ff_keep: got fail %0d ff %0d want 2 4", fail_cnt_o, first_fail_o); end
  endtask

  task automatic test_a128_wrap();
    bit got, ok, ee, rl; int lat;
    logic [127:0] top;
    top = 128'd1 << 127;
    run(3'b011, 3'b100, {top, top}, '0, {2{128'd2}}, '0, '0, '0,
        8'h0, 8'h0, -1, got, ok, ee, lat, rl);
    sb_step(1, -1, 130);
    checks++; if (!got || ok !== 1'b1 || lat != 130) begin errors++; $display("FAIL a128_wrap: got %0b/%0b lat %0d want 1/1 lat 130", got, ok, lat); end
  endtask

  task automatic test_e32();
    bit got, ok, ee, rl; int lat;
    run(3'b000, 3'b001, {8{32'd1}}, '0, {8{32'd1}}, '0, {8{32'd1}}, '0,
        8'hFE, 8'h00, -1, got, ok, ee, lat, rl);
    sb_step(0, -1, 34);
    checks++; if (!got || ok !== 1'b0 || ee !== 1'b1) begin errors++; $display("FAIL e32_bad: got ok %0b eerr %0b want 0 1", ok, ee); end
    run(3'b000, 3'b001, {8{32'd1}}, '0, {8{32'd1}}, '0, {8{32'd1}}, '0,
        8'h0F, 8'hF0, -1, got, ok, ee, lat, rl);
    sb_step(1, -1, 34);
    checks++; if (!got || ok !== 1'b1 || ee !== 1'b0) begin errors++; $display("FAIL e32_good: got ok %0b eerr %0b want 1 0", ok, ee); end
  endtask

  task automatic test_rst_mid();
    bit seen;
    width_i = 3'b001; mode_i = 3'b100;
    a0_i = r256(); a1_i = r256(); b0_i = r256(); b1_i = r256();
    vld_i = 1'b1;
    @(posedge clk); #1 vld_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    sb_clear();
    checks++; if (rdy_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_rdy: got %0b/%0b want 1/0", rdy_o, busy_o); end
    checks++; if (idx_o !== 32'd0 || first_fail_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_mid_regs: got idx %0d ff %h want 0 ffffffff", idx_o, first_fail_o); end
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (res_vld_o !== 1'b0) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rst_mid_strobe: got 1 want 0"); end
  endtask

  task automatic test_clr_cmp();
    bit got, ok, ee, rl; int lat;
    run(3'b000, 3'b100, {8{32'd1}}, {8{32'd2}}, {8{32'd5}}, '0,
        {8{32'hFFFF_FFFF}}, {8{32'd16}}, 8'h0, 8'h0, 34, got, ok, ee, lat, rl);
    sb_step(1, 34, 34);
    checks++; if (!got || ok !== 1'b1 || lat != 34) begin errors++; $display("FAIL clr_cmp_res: got %0b/%0b lat %0d want 1/1 lat 34", got, ok, lat); end
    checks++; if ({pass_cnt_o, fail_cnt_o, idx_o} !== 96'd0) begin errors++; $display("FAIL clr_cmp_cnt: got %h want 0", {pass_cnt_o, fail_cnt_o, idx_o}); end
    run(3'b000, 3'b010, 256'h1, '0, 256'h1, '0, '0, '0, 8'h0, 8'h0,
        0, got, ok, ee, lat, rl);
    sb_step(0, 0, 2);
    checks++; if (idx_o !== 32'd1 || first_fail_o !== 32'd0 || fail_cnt_o !== 32'd1) begin errors++; $display("FAIL clr_accept: got idx %0d ff %0d fail %0d want 1 0 1", idx_o, first_fail_o, fail_cnt_o); end
  endtask

  task automatic test_bad_mode();
    bit got, ok, ee, rl; int lat;
    run(3'b000, 3'b011, {8{32'd1}}, '0, {8{32'd1}}, '0, {8{32'd1}}, '0,
        8'h0, 8'h0, -1, got, ok, ee, lat, rl);
    sb_step(0, -1, 2);
    checks++; if (!got || ok !== 1'b0 || ee !== 1'b0 || lat != 2) begin errors++; $display("FAIL bad_mode: got %0b ok %0b eerr %0b lat %0d want 1 0 0 2", got, ok, ee, lat); end
    checks++; if (fail_cnt_o !== exp_fail) begin errors++; $display("FAIL bad_mode_cnt: got %0d want %0d", fail_cnt_o, exp_fail); end
  endtask

  task automatic test_random();
    bit got, ok, ee, rl, eok, eee; int lat, elat, clr_at, k;
    logic [2:0] w, m;
    logic [255:0] a0, a1, b0, b1, c0, c1; logic [7:0] e0, e1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: w = 3'b000; 1: w = 3'b001; 2: w = 3'b011; default: w = 3'b111;
      endcase
      case ($urandom_range(0, 2))
        0: m = 3'b100; 1: m = 3'b001; default: m = 3'b010;
      endcase
      if ($urandom_range(0, 9) == 0) m = 3'b011;
      if ($urandom_range(0, 9) == 0) w = 3'b010;
      a0 = r256(); a1 = r256(); b0 = r256(); b1 = r256(); c0 = r256();
      e0 = 8'($urandom);
      mk_valid(w, m, a0, a1, b0, b1, c0, e0, c1, e1);
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 255);
        c1[k] = ~c1[k];
      end
      if (m == 3'b001 && $urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 7);
        e1[k] = ~e1[k];
      end
      clr_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40)) : -1;
      model(w, m, a0, a1, b0, b1, c0, c1, e0, e1, eok, eee, elat);
      run(w, m, a0, a1, b0, b1, c0, c1, e0, e1, clr_at, got, ok, ee, lat, rl);
      sb_step(eok, clr_at, elat);
      checks++; if (!got || ok !== eok || ee !== eee || lat != elat) begin errors++; $display("FAIL rnd_res[%0d]: got %0b ok %0b eerr %0b lat %0d want 1 %0b %0b %0d", n, got, ok, ee, lat, eok, eee, elat); end
      checks++; if (pass_cnt_o !== exp_pass || fail_cnt_o !== exp_fail) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", n, pass_cnt_o, fail_cnt_o, exp_pass, exp_fail); end
      checks++; if (idx_o !== exp_idx || first_fail_o !== exp_ff) begin errors++; $display("FAIL rnd_idx[%0d]: got %0d ff %h want %0d ff %h", n, idx_o, first_fail_o, exp_idx, exp_ff); end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_bool();
    test_a32();
    test_a256_fail();
    test_a128_wrap();
    test_e32();
    test_bad_mode();
    test_clr_cmp();
    test_random();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
